// File: rtl/cv32e40p_xif_buffer_pkg.sv
// cv32e40p_xif_buffer_pkg: shared entry types and default widths for the XIF commit buffer
package cv32e40p_xif_buffer_pkg;
  localparam int XBUF_ID_WIDTH = 4;
  localparam int XBUF_NUM_RS = 2;
  typedef enum logic [1:0] {EMPTY, WAIT_COMMIT, COMMITTED, KILLED} entry_state_e;
  typedef struct packed {
    entry_state_e                state;
    logic [31:0]                 instr;
    logic [XBUF_ID_WIDTH-1:0]    id;
    logic [XBUF_NUM_RS*32-1:0]   rs;
    logic                        writeback;
  } xbuf_entry_t;
endpackage

// File: rtl/cv32e40p_xif_id_match.sv
// cv32e40p_xif_id_match: per-entry id compare giving a one-hot commit match and a live-id hit for issue
module cv32e40p_xif_id_match #(
  parameter int DEPTH = 4,
  parameter int X_ID_WIDTH = 4
) (
  input  logic [DEPTH*X_ID_WIDTH-1:0] ids,
  input  logic [DEPTH-1:0]            live,
  input  logic [DEPTH-1:0]            waiting,
  input  logic                        commit_valid,
  input  logic [X_ID_WIDTH-1:0]       commit_id,
  input  logic [X_ID_WIDTH-1:0]       issue_id,
  output logic [DEPTH-1:0]            commit_hit,
  output logic                        issue_hit
);
  logic [DEPTH-1:0] live_hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign commit_hit[i] = commit_valid & waiting[i] & (ids[i*X_ID_WIDTH +: X_ID_WIDTH] == commit_id);
    assign live_hit[i] = live[i] & (ids[i*X_ID_WIDTH +: X_ID_WIDTH] == issue_id);
  end
  assign issue_hit = |live_hit;
endmodule

// File: rtl/cv32e40p_xif_commit_buffer.sv
// cv32e40p_xif_commit_buffer: in-order XIF issue buffer that holds offloaded instructions until commit and dispatches them in program order
module cv32e40p_xif_commit_buffer
  import cv32e40p_xif_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int X_ID_WIDTH = XBUF_ID_WIDTH,
  parameter int X_NUM_RS = XBUF_NUM_RS
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       x_issue_valid_i,
  output logic                       x_issue_ready_o,
  input  logic [31:0]                x_issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]      x_issue_id_i,
  input  logic [X_NUM_RS*32-1:0]     x_issue_rs_i,
  input  logic [X_NUM_RS-1:0]        x_issue_rs_valid_i,
  output logic                       x_issue_accept_o,
  output logic                       x_issue_writeback_o,
  output logic [31:0]                dec_instr_o,
  input  logic                       dec_accept_i,
  input  logic                       dec_writeback_i,
  input  logic [X_NUM_RS-1:0]        dec_needs_rs_i,
  input  logic                       x_commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]      x_commit_id_i,
  input  logic                       x_commit_kill_i,
  output logic                       cop_valid_o,
  input  logic                       cop_ready_i,
  output logic [31:0]                cop_instr_o,
  output logic [X_ID_WIDTH-1:0]      cop_id_o,
  output logic [X_NUM_RS*32-1:0]     cop_rs_o,
  output logic                       cop_writeback_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                       commit_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  xbuf_entry_t                 ent [DEPTH];
  logic [AW-1:0]               head, tail;
  logic [CW-1:0]               cnt;
  logic [DEPTH*X_ID_WIDTH-1:0] ids;
  logic [DEPTH-1:0]            live, waiting, commit_hit;
  logic                        issue_hit, alloc, same_commit, retire, err_q;
  logic [X_NUM_RS*32-1:0]      rs_masked;
  entry_state_e                commit_state;
  always_comb begin
    ids = '0;
    live = '0;
    waiting = '0;
    rs_masked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ids[i*X_ID_WIDTH +: X_ID_WIDTH] = ent[i].id;
      live[i] = ent[i].state != EMPTY;
      waiting[i] = ent[i].state == WAIT_COMMIT;
    end
    for (int i = 0; i < X_NUM_RS; i++)
      rs_masked[i*32 +: 32] = dec_needs_rs_i[i] ? x_issue_rs_i[i*32 +: 32] : 32'd0;
  end
  cv32e40p_xif_id_match #(
    .DEPTH(DEPTH),
    .X_ID_WIDTH(X_ID_WIDTH)
  ) u_id_match (
    .ids(ids),
    .live(live),
    .waiting(waiting),
    .commit_valid(x_commit_valid_i),
    .commit_id(x_commit_id_i),
    .issue_id(x_issue_id_i),
    .commit_hit(commit_hit),
    .issue_hit(issue_hit)
  );
  assign x_issue_ready_o = rst_ni & ((dec_needs_rs_i & ~x_issue_rs_valid_i) == '0) & ~issue_hit
                         & (~dec_accept_i | (cnt != CW'(DEPTH)));
  assign x_issue_accept_o = dec_accept_i;
  assign x_issue_writeback_o = dec_accept_i & dec_writeback_i;
  assign dec_instr_o = x_issue_instr_i;
  assign alloc = x_issue_valid_i & x_issue_ready_o & dec_accept_i;
  assign same_commit = alloc & x_commit_valid_i & (x_commit_id_i == x_issue_id_i);
  assign commit_state = x_commit_kill_i ? KILLED : COMMITTED;
  assign retire = (ent[head].state == KILLED) | ((ent[head].state == COMMITTED) & cop_ready_i);
  assign cop_valid_o = ent[head].state == COMMITTED;
  assign cop_instr_o = ent[head].instr;
  assign cop_id_o = ent[head].id;
  assign cop_rs_o = ent[head].rs;
  assign cop_writeback_o = ent[head].writeback;
  assign occupancy_o = cnt;
  assign commit_err_o = err_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head <= '0;
      tail <= '0;
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (commit_hit[i]) ent[i].state <= commit_state;
      if (alloc)
        ent[tail] <= '{state: same_commit ? commit_state : WAIT_COMMIT, instr: x_issue_instr_i,
                       id: x_issue_id_i, rs: rs_masked, writeback: dec_writeback_i};
      if (retire) ent[head].state <= EMPTY;
      head <= head + AW'(retire);
      tail <= tail + AW'(alloc);
      cnt <= cnt + CW'(alloc) - CW'(retire);
      err_q <= x_commit_valid_i & ~(|commit_hit) & ~same_commit;
    end
  end
endmodule

// File: tb/tb_cv32e40p_xif_commit_buffer.sv
// tb_cv32e40p_xif_commit_buffer: directed and random stimulus against a queue-based program-order model with a dispatch scoreboard
module tb_cv32e40p_xif_commit_buffer;
  localparam int DEPTH = 4;
  localparam int WAIT_S = 0;
  localparam int COMM_S = 1;
  localparam int KILL_S = 2;
  typedef struct {
    logic [3:0]  id;
    logic [31:0] instr;
    logic [63:0] rs;
    logic        wb;
    int          st;
  } ment_t;
  logic clk = 1'b0;
  logic rstn, iv, acc, wb, cv, kill, crdy;
  logic [3:0] iid, cid;
  logic [31:0] instr;
  logic [63:0] rs;
  logic [1:0] rsv, needs;
  logic ready, accept, wbo, cop_valid, cop_wb, err;
  logic [31:0] dec_instr, cop_instr;
  logic [3:0] cop_id;
  logic [63:0] cop_rs;
  logic [2:0] occ;
  ment_t q[$];
  ment_t exp_q[$];
  logic err_e;
  int n_chk, n_pass;
  always #5 clk = ~clk;
  cv32e40p_xif_commit_buffer dut (
    .clk_i(clk),
    .rst_ni(rstn),
    .x_issue_valid_i(iv),
    .x_issue_ready_o(ready),
    .x_issue_instr_i(instr),
    .x_issue_id_i(iid),
    .x_issue_rs_i(rs),
    .x_issue_rs_valid_i(rsv),
    .x_issue_accept_o(accept),
    .x_issue_writeback_o(wbo),
    .dec_instr_o(dec_instr),
    .dec_accept_i(acc),
    .dec_writeback_i(wb),
    .dec_needs_rs_i(needs),
    .x_commit_valid_i(cv),
    .x_commit_id_i(cid),
    .x_commit_kill_i(kill),
    .cop_valid_o(cop_valid),
    .cop_ready_i(crdy),
    .cop_instr_o(cop_instr),
    .cop_id_o(cop_id),
    .cop_rs_o(cop_rs),
    .cop_writeback_o(cop_wb),
    .occupancy_o(occ),
    .commit_err_o(err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic idle();
    iv = 0; iid = 0; acc = 0; wb = 0; needs = 0; rsv = 2'b11; cv = 0; cid = 0; kill = 0;
    instr = 0; rs = 0;
  endtask
  task automatic set_issue(input logic [3:0] id, input logic a, input logic [1:0] nd, input logic [1:0] rv);
    iv = 1; iid = id; acc = a; needs = nd; rsv = rv;
    wb = 1'($urandom); instr = $urandom; rs = {$urandom, $urandom};
  endtask
  task automatic set_commit(input logic [3:0] id, input logic k);
    cv = 1; cid = id; kill = k;
  endtask
  task automatic cycle();
    logic rdy_e, hit, alloc, ret, found;
    ment_t e;
    hit = 0;
    foreach (q[i]) if (q[i].id == iid) hit = 1;
    rdy_e = rstn && ((needs & ~rsv) == 2'b00) && !hit && (!acc || q.size() != DEPTH);
    alloc = iv && rdy_e && acc;
    ret = rstn && q.size() > 0 && (q[0].st == KILL_S || (q[0].st == COMM_S && crdy));
    if (ret && q[0].st == COMM_S) exp_q.push_back(q[0]);
    @(negedge clk);
    chk("issue_ready", ready, rdy_e);
    chk("issue_accept", accept, acc);
    chk("issue_writeback", wbo, acc & wb);
    chk("dec_instr", dec_instr, instr);
    chk("cop_valid", cop_valid, q.size() > 0 && q[0].st == COMM_S);
    chk("occupancy", occ, q.size());
    chk("commit_err", err, err_e);
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      err_e = 0;
    end else begin
      found = 0;
      if (cv) foreach (q[i]) if (q[i].st == WAIT_S && q[i].id == cid) begin
        q[i].st = kill ? KILL_S : COMM_S;
        found = 1;
      end
      if (alloc) begin
        e.id = iid; e.instr = instr; e.wb = wb;
        e.rs = {needs[1] ? rs[63:32] : 32'd0, needs[0] ? rs[31:0] : 32'd0};
        e.st = WAIT_S;
        if (cv && cid == iid) begin
          e.st = kill ? KILL_S : COMM_S;
          found = 1;
        end
        q.push_back(e);
      end
      err_e = cv && !found;
      if (ret) void'(q.pop_front());
    end
    #1;
    idle();
  endtask
  task automatic drain();
    crdy = 1;
    for (int n = 0; n < 40 && q.size() > 0; n++) begin
      for (int i = 0; i < q.size(); i++) if (q[i].st == WAIT_S) begin
        set_commit(q[i].id, 1'($urandom_range(0, 3) == 0));
        break;
      end
      cycle();
    end
    cycle();
    chk("drain_occupancy", occ, 0);
  endtask
  initial forever begin
    ment_t e;
    @(negedge clk);
    if (rstn && cop_valid && crdy) begin
      if (exp_q.size() == 0) chk("unexpected_dispatch", {60'd0, cop_id}, 64'hffff);
      else begin
        e = exp_q.pop_front();
        chk("cop_id", cop_id, e.id);
        chk("cop_instr", cop_instr, e.instr);
        chk("cop_rs", cop_rs, e.rs);
        chk("cop_writeback", cop_wb, e.wb);
      end
    end
  end
  initial begin
    int w[$];
    n_chk = 0; n_pass = 0; err_e = 0;
    rstn = 0; crdy = 0;
    idle();
    @(posedge clk);
    #1;
    cycle();
    chk("reset_occupancy", occ, 0);
    chk("reset_cop_valid", cop_valid, 0);
    rstn = 1;
    set_issue(4'd3, 1, 2'b11, 2'b11);
    cycle();
    cycle();
    crdy = 1;
    set_commit(4'd3, 0);
    cycle();
    chk("t1_cop_valid", cop_valid, 1);
    chk("t1_cop_id", cop_id, 3);
    chk("t1_occupancy", occ, 1);
    cycle();
    chk("t1_occupancy_after", occ, 0);
    for (int i = 1; i <= 3; i++) begin
      set_issue(4'(i), 1, 2'b11, 2'b11);
      cycle();
    end
    set_commit(4'd2, 1); cycle();
    set_commit(4'd1, 0); cycle();
    set_commit(4'd3, 0); cycle();
    drain();
    crdy = 0;
    for (int i = 4; i <= 7; i++) begin
      set_issue(4'(i), 1, 2'b01, 2'b11);
      cycle();
    end
    set_issue(4'd8, 1, 2'b00, 2'b11);
    cycle();
    set_issue(4'd9, 0, 2'b00, 2'b11);
    cycle();
    chk("full_occupancy", occ, 4);
    for (int i = 4; i <= 7; i++) begin
      set_commit(4'(i), 0);
      cycle();
    end
    drain();
    set_issue(4'd5, 1, 2'b10, 2'b11);
    set_commit(4'd5, 0);
    cycle();
    chk("same_cycle_cop_valid", cop_valid, 1);
    chk("same_cycle_cop_id", cop_id, 5);
    drain();
    set_commit(4'd7, 0);
    cycle();
    chk("err_pulse", err, 1);
    cycle();
    chk("err_clear", err, 0);
    crdy = 0;
    set_issue(4'd10, 1, 2'b00, 2'b11); cycle();
    set_issue(4'd10, 1, 2'b00, 2'b11); cycle();
    set_commit(4'd10, 0);
    set_issue(4'd10, 1, 2'b00, 2'b11); cycle();
    set_issue(4'd10, 1, 2'b00, 2'b11); cycle();
    crdy = 1;
    cycle();
    set_issue(4'd10, 1, 2'b00, 2'b11); cycle();
    drain();
    crdy = 0;
    for (int i = 11; i <= 13; i++) begin
      set_issue(4'(i), 1, 2'b11, 2'b11);
      if (i == 11) set_commit(4'(i), 0);
      cycle();
    end
    rstn = 0;
    set_issue(4'd14, 1, 2'b00, 2'b11);
    cycle();
    rstn = 1;
    cycle();
    chk("mid_reset_occupancy", occ, 0);
    chk("mid_reset_cop_valid", cop_valid, 0);
    set_issue(4'd1, 1, 2'b11, 2'b01); cycle();
    set_issue(4'd1, 1, 2'b01, 2'b01); cycle();
    drain();
    for (int n = 0; n < 3000; n++) begin
      rstn = $urandom_range(0, 299) != 0;
      crdy = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 1) == 1)
        set_issue(4'($urandom), $urandom_range(0, 7) != 0, 2'($urandom),
                  $urandom_range(0, 5) == 0 ? 2'($urandom) : 2'b11);
      if ($urandom_range(0, 1) == 1) begin
        w.delete();
        foreach (q[i]) if (q[i].st == WAIT_S) w.push_back(int'(q[i].id));
        if ($urandom_range(0, 7) == 0) set_commit(iid, 1'($urandom_range(0, 3) == 0));
        else if (w.size() > 0 && $urandom_range(0, 7) != 0)
          set_commit(4'(w[$urandom_range(0, w.size() - 1)]), 1'($urandom_range(0, 3) == 0));
        else set_commit(4'($urandom), 1'($urandom));
      end
      cycle();
    end
    rstn = 1;
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
